// File: rtl/alu_uart_sequencer_pkg.sv
// Shared constants for the UART-driven ALU command sequencer:
// FSM state encodings, ALU opcodes and flag bit positions.
package alu_uart_sequencer_pkg;

  localparam logic [2:0] WAIT_A   = 3'd0;
  localparam logic [2:0] WAIT_B   = 3'd1;
  localparam logic [2:0] WAIT_OP  = 3'd2;
  localparam logic [2:0] EXEC     = 3'd3;
  localparam logic [2:0] SEND_RES = 3'd4;
  localparam logic [2:0] WAIT_RES = 3'd5;
  localparam logic [2:0] SEND_FLG = 3'd6;
  localparam logic [2:0] WAIT_FLG = 3'd7;

  localparam logic [3:0] OP_ADD = 4'd8;
  localparam logic [3:0] OP_SUB = 4'd10;
  localparam logic [3:0] OP_AND = 4'd12;
  localparam logic [3:0] OP_OR  = 4'd13;
  localparam logic [3:0] OP_XOR = 4'd14;
  localparam logic [3:0] OP_SRA = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd2;

  // Bit positions within the packed {exception, negative, overflow, carry, zero}
  localparam int FLG_ZERO      = 0;
  localparam int FLG_CARRY     = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_NEGATIVE  = 3;
  localparam int FLG_EXCEPTION = 4;

endpackage

// File: rtl/alu_uart_sequencer_timeout_counter.sv
// Idle-cycle counter; expired is high while the count sits at LIMIT-1.
module timeout_counter #(
  parameter int LIMIT = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(LIMIT - 1));

  // Holds at LIMIT-1 so a late clear never sees a wrapped value
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)                count <= '0;
    else if (clear)              count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, runs
// them through an external ALU, and sends back the result byte then the flags.
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [4:0]            i_alu_flags,
  output logic [DATA_WIDTH-1:0] o_operandA,
  output logic [DATA_WIDTH-1:0] o_operandB,
  output logic [3:0]            o_opcode,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic                  o_rx_drop
);

  logic [2:0]            state, state_nxt;
  logic [DATA_WIDTH-1:0] result_q, flag_q;
  logic                  wait_byte, accept, expired, tmo_clear;

  assign o_busy     = (state == EXEC) || (state == SEND_RES) || (state == WAIT_RES) ||
                      (state == SEND_FLG) || (state == WAIT_FLG);
  assign o_tx_start = (state == SEND_RES) || (state == SEND_FLG);
  assign wait_byte  = (state == WAIT_B) || (state == WAIT_OP);
  assign accept     = i_rx_done && !o_busy;
  assign o_rx_drop  = i_rx_done && o_busy;
  // A byte landing on the expiry cycle takes priority over the timeout
  assign o_timeout  = wait_byte && expired && !i_rx_done;
  assign tmo_clear  = accept || (state == WAIT_A) || o_timeout;

  timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .clear   (tmo_clear),
    .enable  (wait_byte),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_A:   if (i_rx_done) state_nxt = WAIT_B;
      WAIT_B:   if (i_rx_done) state_nxt = WAIT_OP;
                else if (o_timeout) state_nxt = WAIT_A;
      WAIT_OP:  if (i_rx_done) state_nxt = EXEC;
                else if (o_timeout) state_nxt = WAIT_A;
      EXEC:     state_nxt = SEND_RES;
      SEND_RES: state_nxt = WAIT_RES;
      WAIT_RES: if (i_tx_done) state_nxt = SEND_FLG;
      SEND_FLG: state_nxt = WAIT_FLG;
      WAIT_FLG: if (i_tx_done) state_nxt = WAIT_A;
      default:  state_nxt = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= WAIT_A;
      o_operandA <= '0;
      o_operandB <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
      result_q   <= '0;
      flag_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        WAIT_A:   if (i_rx_done) o_operandA <= i_rx_data;
        WAIT_B:   if (i_rx_done) o_operandB <= i_rx_data;
        WAIT_OP:  if (i_rx_done) o_opcode   <= i_rx_data[3:0];
        EXEC: begin
          result_q  <= i_alu_result;
          flag_q    <= DATA_WIDTH'({3'b000, i_alu_flags});
          o_tx_data <= i_alu_result;
        end
        WAIT_RES: if (i_tx_done) o_tx_data <= flag_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a stubbed ALU and a short timeout.
module tb_alu_uart_sequencer;

  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_done = 1'b0;
  logic          tx_done = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic [4:0]    alu_flags = '0;
  logic [DW-1:0] operand_a, operand_b, tx_data;
  logic [3:0]    opcode;
  logic          tx_start, busy, timeout, rx_drop;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_uart_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .i_alu_flags  (alu_flags),
    .o_operandA   (operand_a),
    .o_operandB   (operand_b),
    .o_opcode     (opcode),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_timeout    (timeout),
    .o_rx_drop    (rx_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
  endtask

  // Called in the EXEC cycle (one cycle after the opcode strobe)
  task automatic tx_tail(input logic [DW-1:0] res, input logic [DW-1:0] flg_byte, input int drops);
    chk("exec_busy", busy, 1);
    chk("exec_no_start", tx_start, 0);
    @(negedge clk);
    chk("res_start", tx_start, 1);
    chk("res_data", tx_data, res);
    alu_result = ~res;
    @(negedge clk);
    chk("res_start_one_cycle", tx_start, 0);
    chk("res_data_stable", tx_data, res);
    for (int i = 0; i < drops; i++) begin
      @(negedge clk); rx_data = 8'h55; rx_done = 1'b1;
      #1 chk("drop_pulse", rx_drop, 1);
      @(negedge clk); rx_done = 1'b0;
      #1 chk("drop_low", rx_drop, 0);
    end
    chk("wait_res_busy", busy, 1);
    pulse_tx_done();
    chk("flg_start", tx_start, 1);
    chk("flg_data", tx_data, flg_byte);
    @(negedge clk);
    chk("flg_start_one_cycle", tx_start, 0);
    chk("wait_flg_busy", busy, 1);
    pulse_tx_done();
    chk("idle_after_cmd", busy, 0);
  endtask

  task automatic run_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] opb,
                         input logic [DW-1:0] res, input logic [4:0] flg, input int drops);
    alu_result = res;
    alu_flags  = flg;
    send_byte(a);  chk("opA", operand_a, a);
    send_byte(b);  chk("opB", operand_b, b);
    send_byte(opb); chk("opcode", opcode, opb[3:0]);
    tx_tail(res, {3'b000, flg}, drops);
    chk("opA_kept", operand_a, a);
    chk("opB_kept", operand_b, b);
  endtask

  initial begin
    #12;
    chk("rst_opA", operand_a, 0);
    chk("rst_opB", operand_b, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rx_drop", rx_drop, 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic ADD command: result 0x08, flags 0x00
    run_cmd(8'h05, 8'h03, 8'h08, 8'h08, 5'b00000, 0);

    // Upper opcode bits ignored; flags byte zero-extended
    run_cmd(8'h12, 8'h34, 8'hFA, 8'hDE, 5'b00110, 0);

    // Exception flag set: both bytes still sent
    run_cmd(8'h40, 8'h02, 8'h03, 8'h10, 5'b10001, 0);

    // Bytes received while transmitting are dropped
    run_cmd(8'h11, 8'h22, 8'h08, 8'h33, 5'b00000, 3);
    run_cmd(8'hA0, 8'h0F, 8'h0D, 8'hAF, 5'b01000, 0);

    // Timeout after operand A
    send_byte(8'h01);
    for (int i = 0; i < TMO - 1; i++) begin
      chk("no_early_timeout", timeout, 0);
      @(negedge clk);
    end
    chk("timeout_pulse", timeout, 1);
    chk("timeout_not_busy", busy, 0);
    @(negedge clk);
    chk("timeout_one_cycle", timeout, 0);
    chk("timeout_opA_kept", operand_a, 8'h01);
    send_byte(8'h07);
    chk("post_timeout_opA", operand_a, 8'h07);
    chk("post_timeout_opB_kept", operand_b, 8'h0F);

    // Byte on the exact expiry cycle wins
    repeat (TMO - 2) @(negedge clk);
    @(negedge clk); rx_data = 8'h09; rx_done = 1'b1;
    #1 chk("expiry_byte_no_timeout", timeout, 0);
    @(negedge clk); rx_done = 1'b0;
    chk("expiry_byte_opB", operand_b, 8'h09);
    chk("expiry_byte_timeout_low", timeout, 0);
    alu_result = 8'h01; alu_flags = 5'b00010;
    send_byte(8'h0C);
    chk("expiry_opcode", opcode, 4'hC);
    tx_tail(8'h01, 8'h02, 0);

    // tx_done while idle is ignored
    pulse_tx_done();
    chk("stray_txdone_busy", busy, 0);
    chk("stray_txdone_start", tx_start, 0);

    // Reset during WAIT_RES
    alu_result = 8'h77; alu_flags = 5'b00001;
    send_byte(8'h21); send_byte(8'h43); send_byte(8'h0E);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_opA", operand_a, 0);
    chk("mid_rst_opB", operand_b, 0);
    chk("mid_rst_opcode", opcode, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    @(negedge clk); rst_n = 1'b1;
    run_cmd(8'h05, 8'h06, 8'h0A, 8'hFF, 5'b01010, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
ALU_UART_SEQUENCER -- requirements
Module: alu_uart_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning max idle cycles allowed between bytes of one command.
REQ-003 The block SHALL have port i_clock  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_rx_data  input  DATA_WIDTH  received byte, valid only while i_rx_done is high.
REQ-006 The block SHALL have port i_rx_done  input  1  one-cycle strobe marking a received byte.
REQ-007 The block SHALL have port i_tx_done  input  1  one-cycle strobe marking transmitter completion.
REQ-008 The block SHALL have port i_alu_result  input  DATA_WIDTH  combinational ALU result.
REQ-009 The block SHALL have port i_alu_flags  input  5  ALU flags packed {exception, negative, overflow, carry, zero}.
REQ-010 The block SHALL have port o_operandA / o_operandB  output  DATA_WIDTH  registered ALU operands.
REQ-011 The block SHALL have port o_opcode  output  4  registered ALU opcode.
REQ-012 The block SHALL have port o_tx_data  output  DATA_WIDTH  byte to transmit, stable from o_tx_start until i_tx_done.
REQ-013 The block SHALL have port o_tx_start  output  1  one-cycle transmit request.
REQ-014 The block SHALL have ports o_busy, o_timeout, o_rx_drop  output  1 each  status: command in execution/transmit; timeout pulse; dropped-byte pulse.

Function
REQ-015 The FSM SHALL have states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-016 In WAIT_A/WAIT_B, i_rx_done SHALL capture i_rx_data into o_operandA/o_operandB and advance to WAIT_B/WAIT_OP next cycle.
REQ-017 In WAIT_OP, i_rx_done SHALL capture i_rx_data[3:0] into o_opcode (upper bits ignored) and advance to EXEC.
REQ-018 EXEC SHALL last exactly one cycle, registering i_alu_result and {3'b0, i_alu_flags} into internal result/flag registers, then go to SEND_RES.
REQ-019 SEND_RES SHALL drive o_tx_data = result and assert o_tx_start for one cycle, then go to WAIT_RES.
REQ-020 WAIT_RES SHALL hold until i_tx_done, then go to SEND_FLG; SEND_FLG/WAIT_FLG SHALL repeat with the flags byte, returning to WAIT_A on i_tx_done.
REQ-021 Latency: opcode strobe at cycle N SHALL give o_tx_start with result at cycle N+2.
REQ-022 o_busy SHALL be high in EXEC through WAIT_FLG, low otherwise.
REQ-023 An i_rx_done while o_busy is high SHALL be discarded, with o_rx_drop pulsed that same cycle; state unaffected.
REQ-024 A timeout counter SHALL clear on every accepted byte and on entry to WAIT_A, and count cycles only in WAIT_B/WAIT_OP.
REQ-025 On reaching TIMEOUT_CYCLES-1 without a byte, the FSM SHALL return to WAIT_A and pulse o_timeout for one cycle; operands retain their values.
REQ-026 A byte arriving in the same cycle as timeout expiry SHALL win: it is accepted and no timeout is raised.
REQ-027 i_tx_done outside WAIT_RES/WAIT_FLG SHALL be ignored.
REQ-028 The ALU exception flag SHALL NOT alter sequencing; both bytes are always sent.

Reset
REQ-029 On i_reset low, the FSM SHALL enter WAIT_A immediately, abandoning any command or transmission in progress.
REQ-030 Reset values SHALL be 0 for o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout, o_rx_drop, timeout counter, result and flag registers.

Structure
REQ-031 State encodings, the opcode constants (ADD 8, SUB 10, AND 12, OR 13, XOR 14, SRA 3, SRL 2) and flag bit positions SHALL live in a shared package.
REQ-032 The timeout counter SHALL be a sub-module named timeout_counter (clear, enable, expired).

Verification
REQ-033 Bytes 0x05, 0x03, 0x08 with stub result 0x08, flags 0x00 -> o_operandA 0x05, o_operandB 0x03, o_opcode 0x8; tx bytes 0x08 then 0x00; start at N+2.
REQ-034 Opcode byte 0xFA -> o_opcode 0xA; stub flags 5'b00110 -> flags byte 0x06.
REQ-035 0x11, then 3 bytes during transmission -> 3 o_rx_drop pulses; outputs 0x11/0x22 path unaffected; next command processed normally.
REQ-036 TIMEOUT_CYCLES=16: byte 0x01 then silence -> o_timeout at 15 cycles after accept, FSM in WAIT_A; next byte loads o_operandA.
REQ-037 i_reset low during WAIT_RES -> o_tx_start/o_busy 0 immediately, all outputs at reset values; new command completes normally.
REQ-038 Byte strobe on exact timeout-expiry cycle -> byte accepted, no o_timeout pulse.
